seg_display_ctrl: RTL

//  Drives the board's 3-digit multiplexed, active-low 7-segment display from
//  the 12-bit seg_digits status word (3 hex nibbles) built by the status logic.

---
 rtl/seg_display_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: 3-digit multiplexed active-low 7-segment driver.
// Define SEG_BLINK_EN to add the blink port and frame-based blanking.
module seg_display_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int GUARD        = 500,
  parameter int BLINK_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] seg_digits,
`ifdef SEG_BLINK_EN
  input  logic        blink,
`endif
  output logic [7:0]  seg,
  output logic [2:0]  anodes
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [1:0]        digit_idx, idx_nx;
  logic [11:0]       frame, frame_nx;
  logic              tick;
  logic              frame_load;
  logic              guard_ok;
  logic              blank_phase;
  logic              blank_now;
  logic              show;
  logic [3:0]        nib;
  logic [7:0]        seg_nx;
  logic [2:0]        an_nx;

  function automatic logic [7:0] decode(input logic [3:0] n);
    logic [7:0] s;
    s = 8'hFF;
    unique case (n)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      4'hF: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick = (div_cnt == DIV_LAST);

  generate
    if (GUARD == 0) begin : g_noguard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      localparam logic [DIV_W-1:0] GUARD_V = DIV_W'(GUARD);
      assign guard_ok = (div_cnt >= GUARD_V);
    end
  endgenerate

  // Next-state: divider, digit scan and once-per-frame word latch.
  always_comb begin
    state_nx   = state;
    idx_nx     = digit_idx;
    frame_nx   = frame;
    frame_load = 1'b0;
    div_nx     = tick ? '0 : div_cnt + 1'b1;
    if (tick) begin
      unique case (state)
        BLANK: begin
          state_nx   = SCAN;
          idx_nx     = 2'd0;
          frame_load = 1'b1;
        end
        SCAN: begin
          if (digit_idx == 2'd2) begin
            idx_nx     = 2'd0;
            frame_load = 1'b1;
          end else begin
            idx_nx = digit_idx + 2'd1;
          end
        end
      endcase
    end
    if (frame_load) frame_nx = seg_digits;
  end

`ifdef SEG_BLINK_EN
  localparam int FC_W =
    (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST =
    FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] frame_cnt;

  // Count frame starts while blinking; flip phase every BLINK_FRAMES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blank_phase <= 1'b0;
    end else if (!blink) begin
      frame_cnt   <= '0;
      blank_phase <= 1'b0;
    end else if (frame_load) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt   <= '0;
        blank_phase <= ~blank_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Gate with blink so dropping it un-blanks on the very next clock.
  assign blank_now = blank_phase & blink;
`else
  assign blank_phase = 1'b0;
  assign blank_now   = blank_phase;
`endif

  // Output selection: one anode low outside the guard window.
  always_comb begin
    nib = frame[11:8];
    unique case (digit_idx)
      2'd0:    nib = frame[3:0];
      2'd1:    nib = frame[7:4];
      default: nib = frame[11:8];
    endcase
    show   = (state == SCAN) && guard_ok && !blank_now;
    seg_nx = show ? decode(nib) : 8'hFF;
    an_nx  = show ? ~(3'b001 << digit_idx) : 3'b111;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= BLANK;
      div_cnt   <= '0;
      digit_idx <= 2'd0;
      frame     <= 12'h000;
      seg       <= 8'hFF;
      anodes    <= 3'b111;
    end else begin
      state     <= state_nx;
      div_cnt   <= div_nx;
      digit_idx <= idx_nx;
      frame     <= frame_nx;
      seg       <= seg_nx;
      anodes    <= an_nx;
    end
  end

endmodule
